fetch_stage: RTL and testbench

Instruction-fetch (IF) stage and IF/ID pipeline register for the pipelined MIPS core. It holds the program counter and drives the instruction-memory address. It registers the fetched word into ID, where it supplies opCode/func to the control decoder. It takes the decoder's branch decision (`pcSrc_IF`) plus the ID-computed target back, to redirect the PC and squash the wrong-path fetch.

---
 rtl/fetch_stage.sv | 88 ++++++++
 tb/tb_fetch_stage.sv | 203 ++++++++++++++++++++
 2 files changed

// File: rtl/fetch_stage.sv
// Instruction-fetch stage with the IF/ID pipeline register: owns the PC, issues
// fetch requests, and squashes the wrong-path word on a taken branch from ID.
module fetch_stage #(
  parameter logic [31:0] RESET_PC     = 32'h0000_0000,
  parameter logic [31:0] BUBBLE_INSTR = 32'h0000_0000
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        stall_ID,
  input  logic        pcSrc_IF,
  input  logic [31:0] branchTarget_ID,
  input  logic        imemReady_IF,
  input  logic [31:0] imemData_IF,
  output logic        imemReq_IF,
  output logic [31:0] imemAddr_IF,
  output logic [31:0] instr_ID,
  output logic [5:0]  opCode_ID,
  output logic [5:0]  func_ID,
  output logic [31:0] pcPlus4_ID,
  output logic        valid_ID,
  output logic [15:0] bubbleCount
);

  localparam logic [0:0] ST_BOOT = 1'b0;
  localparam logic [0:0] ST_RUN  = 1'b1;

  logic [0:0]  r_state;
  logic [31:0] r_pc;
  logic [31:0] r_instr;
  logic [31:0] r_pc_plus4;
  logic        r_valid;
  logic [15:0] r_bubble_count;

  logic        w_active;
  logic        w_load_bubble;
  logic        w_load_instr;
  logic [31:0] w_pc_plus4;

  // Redirect outranks a memory wait, and a stall outranks both.
  assign w_active      = (r_state == ST_RUN) && !stall_ID;
  assign w_load_bubble = w_active && (pcSrc_IF || !imemReady_IF);
  assign w_load_instr  = w_active && !pcSrc_IF && imemReady_IF;
  assign w_pc_plus4    = r_pc + 32'd4;

  // The request is gated by rst_n so it drops as soon as reset is asserted.
  assign imemReq_IF  = rst_n && w_active;
  assign imemAddr_IF = r_pc;
  assign instr_ID    = r_instr;
  assign opCode_ID   = r_instr[31:26];
  assign func_ID     = r_instr[5:0];
  assign pcPlus4_ID  = r_pc_plus4;
  assign valid_ID    = r_valid;
  assign bubbleCount = r_bubble_count;

  // NOTE: sequential state uses non-blocking assignments so every register
  // samples the pre-edge values regardless of statement order.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_state        <= ST_BOOT;
      r_pc           <= RESET_PC;
      r_instr        <= BUBBLE_INSTR;
      r_pc_plus4     <= 32'd0;
      r_valid        <= 1'b0;
      r_bubble_count <= 16'd0;
    end else begin
      if (r_state == ST_BOOT) begin
        r_state <= ST_RUN;
      end
      if (w_load_bubble) begin
        if (pcSrc_IF) begin
          r_pc <= branchTarget_ID;
        end
        r_instr    <= BUBBLE_INSTR;
        r_pc_plus4 <= 32'd0;
        r_valid    <= 1'b0;
        if (r_bubble_count != 16'hFFFF) begin
          r_bubble_count <= r_bubble_count + 16'd1;
        end
      end else if (w_load_instr) begin
        r_pc       <= w_pc_plus4;
        r_instr    <= imemData_IF;
        r_pc_plus4 <= w_pc_plus4;
        r_valid    <= 1'b1;
      end
    end
  end

endmodule

// File: tb/tb_fetch_stage.sv
// Self-checking bench for fetch_stage: directed scenarios pinned by literal
// expectations, then randomized traffic checked every cycle against a model.
module tb_fetch_stage;

  localparam logic [31:0] RST_PC = 32'h0000_0040;
  localparam logic [31:0] BUBBLE = 32'h0000_0000;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        stall_ID;
  logic        pcSrc_IF;
  logic [31:0] branchTarget_ID;
  logic        imemReady_IF;
  logic [31:0] imemData_IF;
  logic        imemReq_IF;
  logic [31:0] imemAddr_IF;
  logic [31:0] instr_ID;
  logic [5:0]  opCode_ID;
  logic [5:0]  func_ID;
  logic [31:0] pcPlus4_ID;
  logic        valid_ID;
  logic [15:0] bubbleCount;

  int n_cmp  = 0;
  int n_fail = 0;
  bit chk_en = 1'b0;

  always #5 clk = ~clk;

  fetch_stage #(.RESET_PC(RST_PC), .BUBBLE_INSTR(BUBBLE)) dut (
    .clk(clk), .rst_n(rst_n), .stall_ID(stall_ID), .pcSrc_IF(pcSrc_IF),
    .branchTarget_ID(branchTarget_ID), .imemReady_IF(imemReady_IF),
    .imemData_IF(imemData_IF), .imemReq_IF(imemReq_IF), .imemAddr_IF(imemAddr_IF),
    .instr_ID(instr_ID), .opCode_ID(opCode_ID), .func_ID(func_ID),
    .pcPlus4_ID(pcPlus4_ID), .valid_ID(valid_ID), .bubbleCount(bubbleCount)
  );

  // Instruction memory: every address holds a distinct scrambled word.
  function automatic logic [31:0] mem_word(input logic [31:0] a);
    return (a * 32'h9E37_79B1) ^ 32'hC001_D00D;
  endfunction

  assign imemData_IF = mem_word(imemAddr_IF);

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s at %0t: got 0x%08h, expected 0x%08h", name, $time, act, exp);
    end
  endtask

  // Reference model: the architectural view of the stage -- a PC, the word
  // sitting in ID (or none), and a saturating bubble tally.
  logic [31:0] m_pc, m_instr, m_p4;
  logic        m_valid, m_started;
  int          m_bubbles;

  always @(posedge clk) begin
    if (!rst_n) begin
      m_pc <= RST_PC; m_started <= 1'b0;
      m_instr <= BUBBLE; m_p4 <= 32'd0; m_valid <= 1'b0; m_bubbles <= 0;
    end else if (!m_started) begin
      m_started <= 1'b1;
    end else if (!stall_ID) begin
      if (pcSrc_IF || !imemReady_IF) begin
        if (pcSrc_IF) m_pc <= branchTarget_ID;
        m_instr <= BUBBLE; m_p4 <= 32'd0; m_valid <= 1'b0;
        m_bubbles <= (m_bubbles < 65535) ? m_bubbles + 1 : 65535;
      end else begin
        m_instr <= mem_word(m_pc); m_p4 <= m_pc + 32'd4; m_valid <= 1'b1;
        m_pc <= m_pc + 32'd4;
      end
    end
  end

  always @(negedge clk) begin
    if (chk_en) begin
      check("req",    {31'd0, imemReq_IF}, {31'd0, rst_n && m_started && !stall_ID});
      check("addr",   imemAddr_IF, m_pc);
      check("instr",  instr_ID, m_instr);
      check("opcode", {26'd0, opCode_ID}, {26'd0, m_instr[31:26]});
      check("func",   {26'd0, func_ID}, {26'd0, m_instr[5:0]});
      check("pc4",    pcPlus4_ID, m_p4);
      check("valid",  {31'd0, valid_ID}, {31'd0, m_valid});
      check("bubcnt", {16'd0, bubbleCount}, m_bubbles[31:0]);
    end
  end

  task automatic cyc(input int n = 1);
    repeat (n) begin
      @(posedge clk);
      #2;
    end
  endtask

  logic [31:0] held_instr;

  initial begin
    rst_n = 1'b0; stall_ID = 1'b0; pcSrc_IF = 1'b0;
    branchTarget_ID = 32'd0; imemReady_IF = 1'b1;
    cyc(2);
    chk_en = 1'b1;
    check("rst_valid", {31'd0, valid_ID}, 32'd0);
    check("rst_bubcnt", {16'd0, bubbleCount}, 32'd0);
    check("rst_req", {31'd0, imemReq_IF}, 32'd0);

    // Boot, then straight-line fetch from RESET_PC.
    rst_n = 1'b1;
    cyc();
    check("first_req", {31'd0, imemReq_IF}, 32'd1);
    check("first_addr", imemAddr_IF, 32'h40);
    cyc();
    check("seq_instr0", instr_ID, mem_word(32'h40));
    check("seq_pc4_0", pcPlus4_ID, 32'h44);
    cyc();
    check("seq_pc4_1", pcPlus4_ID, 32'h48);
    cyc();
    check("seq_instr2", instr_ID, mem_word(32'h48));
    check("seq_pc4_2", pcPlus4_ID, 32'h4C);

    // Taken branch from 0x48 in ID: word from 0x4C is dropped.
    pcSrc_IF = 1'b1; branchTarget_ID = 32'h100;
    cyc();
    pcSrc_IF = 1'b0;
    check("br_addr", imemAddr_IF, 32'h100);
    check("br_valid", {31'd0, valid_ID}, 32'd0);
    check("br_bubcnt", {16'd0, bubbleCount}, 32'd1);
    cyc();
    check("br_instr", instr_ID, mem_word(32'h100));
    check("br_pc4", pcPlus4_ID, 32'h104);

    // Memory wait of three cycles at PC=0x20.
    pcSrc_IF = 1'b1; branchTarget_ID = 32'h20;
    cyc();
    pcSrc_IF = 1'b0; imemReady_IF = 1'b0;
    cyc(3);
    check("wait_addr", imemAddr_IF, 32'h20);
    check("wait_bubcnt", {16'd0, bubbleCount}, 32'd5);
    check("wait_valid", {31'd0, valid_ID}, 32'd0);
    imemReady_IF = 1'b1;
    cyc();
    check("wait_instr", instr_ID, mem_word(32'h20));
    check("wait_addr2", imemAddr_IF, 32'h24);

    // Stall overrides a pending branch; redirect happens once it drops.
    held_instr = instr_ID;
    stall_ID = 1'b1; pcSrc_IF = 1'b1; branchTarget_ID = 32'h200;
    #1 check("stall_req", {31'd0, imemReq_IF}, 32'd0);
    cyc(2);
    check("stall_instr", instr_ID, held_instr);
    check("stall_addr", imemAddr_IF, 32'h24);
    check("stall_bubcnt", {16'd0, bubbleCount}, 32'd5);
    stall_ID = 1'b0;
    cyc();
    pcSrc_IF = 1'b0;
    check("unstall_addr", imemAddr_IF, 32'h200);
    check("unstall_bubcnt", {16'd0, bubbleCount}, 32'd6);

    // PC wraps modulo 2^32.
    pcSrc_IF = 1'b1; branchTarget_ID = 32'hFFFF_FFFC;
    cyc();
    pcSrc_IF = 1'b0;
    check("wrap_addr0", imemAddr_IF, 32'hFFFF_FFFC);
    cyc();
    check("wrap_addr1", imemAddr_IF, 32'h0);
    check("wrap_pc4", pcPlus4_ID, 32'h0);

    // Reset during a stalled branch loses the branch.
    stall_ID = 1'b1; pcSrc_IF = 1'b1; branchTarget_ID = 32'h300;
    cyc();
    rst_n = 1'b0;
    cyc();
    check("mrst_addr", imemAddr_IF, RST_PC);
    check("mrst_valid", {31'd0, valid_ID}, 32'd0);
    rst_n = 1'b1; stall_ID = 1'b0; pcSrc_IF = 1'b0;
    cyc(2);
    check("mrst_no_stale", imemAddr_IF, 32'h44);

    // Randomized traffic, including occasional resets.
    for (int i = 0; i < 3000; i++) begin
      rst_n           = ($urandom_range(0, 299) != 0);
      stall_ID        = ($urandom_range(0, 3) == 0);
      pcSrc_IF        = ($urandom_range(0, 5) == 0);
      imemReady_IF    = ($urandom_range(0, 3) != 0);
      branchTarget_ID = ($urandom_range(0, 7) == 0) ? $urandom() : {$urandom_range(0, 1023), 2'b00};
      cyc();
    end

    // Bubble counter saturation.
    rst_n = 1'b0; stall_ID = 1'b0; pcSrc_IF = 1'b0; imemReady_IF = 1'b0;
    cyc();
    rst_n = 1'b1;
    cyc(65536);
    check("sat_full", {16'd0, bubbleCount}, 32'h0000_FFFF);
    cyc();
    check("sat_hold", {16'd0, bubbleCount}, 32'h0000_FFFF);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
